posit_encoder_rne: RTL and testbench

- Parametrised successor to the fixed 32-bit, es=2 bit-serial posit encoder.
- Packs decoded fields {sign, regime k, exponent, fraction} into an N-bit posit.
- Adds round-to-nearest-even (guard/sticky), saturation to minpos/maxpos, explicit zero/NaR inputs, and a valid/ready handshake on both sides.
- Sits at the output of the posit arithmetic datapath, after normalisation.

---
 rtl/posit_pkg.sv | 31 +++
 rtl/posit_round_rne.sv | 28 ++
 rtl/posit_encoder_rne.sv | 170 +++++++++++++++++
 tb/tb_posit_encoder_rne.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Shared posit definitions: FSM states, special-value constants and default
// format parameters used by the encoder, decoder and rounding stages.
package posit_pkg;

  localparam int unsigned POSIT_N  = 32;
  localparam int unsigned POSIT_ES = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUILD,
    S_ROUND,
    S_SIGN,
    S_OUT
  } state_t;

  // Not-a-Real: sign bit only
  function automatic logic [31:0] nar_const(input int unsigned n);
    return 32'h1 << (n - 1);
  endfunction

  // Largest positive posit: 0 followed by n-1 ones
  function automatic logic [31:0] maxpos_const(input int unsigned n);
    return (32'h1 << (n - 1)) - 32'h1;
  endfunction

  // Smallest positive posit: LSB only
  function automatic logic [31:0] minpos_const(input int unsigned n);
    return 32'(n != 0);
  endfunction

endpackage

// File: rtl/posit_round_rne.sv
// Round-to-nearest-even on an (N-1)-bit posit body given guard and sticky.
// Never wraps past maxpos and never yields zero (forces minpos instead).
module posit_round_rne #(
  parameter int unsigned N = 32
) (
  input  logic [N-2:0] i_body,
  input  logic         i_guard,
  input  logic         i_sticky,
  output logic [N-2:0] o_body
);

  logic         w_up;
  logic [N-2:0] w_sum;

  // Increment on guard when above half or on a tie with odd LSB, then clamp
  always_comb begin
    w_up  = i_guard & (i_body[0] | i_sticky);
    w_sum = i_body + {{(N-2){1'b0}}, w_up};
    if ((&i_body) && w_up) begin
      o_body = '1;
    end else if (w_sum == '0) begin
      o_body = {{(N-2){1'b0}}, 1'b1};
    end else begin
      o_body = w_sum;
    end
  end

endmodule

// File: rtl/posit_encoder_rne.sv
// Bit-serial posit encoder with round-to-nearest-even, saturation and
// zero/NaR handling. Packs {sign, k, exp, frac} into an N-bit posit behind a
// valid/ready handshake on both sides; one operation in flight at a time.
module posit_encoder_rne
  import posit_pkg::*;
#(
  parameter int unsigned N  = POSIT_N,
  parameter int unsigned ES = POSIT_ES,
  parameter int unsigned MW = 32,
  parameter int unsigned KW = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_sign,
  input  logic [KW-1:0]                 in_k,
  input  logic [((ES > 0) ? ES : 1)-1:0] in_exp,
  input  logic [MW-1:0]                 in_frac,
  input  logic                          in_zero,
  input  logic                          in_nar,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N-1:0]                  out_posit,
  output logic                          busy
);

  localparam int unsigned EW   = (ES > 0) ? ES : 1;
  localparam int unsigned FW   = ES + MW;
  localparam int unsigned CW   = $clog2(N) + 1;
  localparam int          K_HI = int'(N) - 2;
  localparam int          K_LO = 1 - int'(N);
  localparam logic [N-1:0] P_NAR = N'(nar_const(N));
  localparam logic [N-1:0] P_MAX = N'(maxpos_const(N));
  localparam logic [N-1:0] P_MIN = N'(minpos_const(N));

  state_t          r_state, w_next;
  logic            r_sign;
  logic [FW-1:0]   r_field;
  logic [CW-1:0]   r_run;
  logic            r_rpol;
  logic            r_term;
  logic [CW-1:0]   r_cnt;
  logic [N-2:0]    r_body;
  logic            r_guard;
  logic            r_sticky;
  logic [N-1:0]    r_result;

  logic            w_accept;
  logic signed [31:0] w_k;
  logic            w_sat_hi;
  logic            w_sat_lo;
  logic [CW-1:0]   w_run;
  logic [EW+MW-1:0] w_cat;
  logic            w_in_regime;
  logic            w_bit;
  logic [FW-1:0]   w_field_next;
  logic            w_last;
  logic [N-2:0]    w_rounded;

  assign w_accept = in_valid & in_ready;
  assign w_k      = {{(32-KW){in_k[KW-1]}}, in_k};
  assign w_sat_hi = (w_k >= K_HI);
  assign w_sat_lo = (w_k <= K_LO);
  assign w_run    = (w_k >= 0) ? CW'(w_k + 1) : CW'(-w_k);
  assign w_cat    = {in_exp, in_frac};

  // Stream source: regime run, then terminator, then exponent/fraction MSB-first
  // (zeros shift in behind the field so exhausted input reads as zero).
  assign w_in_regime  = (r_run != '0) | r_term;
  assign w_bit        = (r_run != '0) ? r_rpol : (r_term ? ~r_rpol : r_field[FW-1]);
  assign w_field_next = w_in_regime ? r_field : (r_field << 1);
  assign w_last       = (r_cnt == CW'(N - 1));

  posit_round_rne #(.N(N)) u_round (
    .i_body   (r_body),
    .i_guard  (r_guard),
    .i_sticky (r_sticky),
    .o_body   (w_rounded)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (in_nar || in_zero)      w_next = S_OUT;
          else if (w_sat_hi || w_sat_lo) w_next = S_SIGN;
          else                        w_next = S_BUILD;
        end
      end
      S_BUILD: if (w_last) w_next = S_ROUND;
      S_ROUND: w_next = S_SIGN;
      S_SIGN:  w_next = S_OUT;
      S_OUT:   if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_OUT);
    busy      = (r_state != S_IDLE);
  end

  assign out_posit = r_result;

  // Datapath: field capture, serial body build, rounding and sign application
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sign   <= 1'b0;
      r_field  <= '0;
      r_run    <= '0;
      r_rpol   <= 1'b0;
      r_term   <= 1'b0;
      r_cnt    <= '0;
      r_body   <= '0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sign   <= in_sign;
            r_field  <= w_cat[FW-1:0];
            r_run    <= w_run;
            r_rpol   <= ~w_k[31];
            r_term   <= 1'b1;
            r_cnt    <= '0;
            r_body   <= '0;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            if (in_nar)        r_result <= P_NAR;
            else if (in_zero)  r_result <= '0;
            else if (w_sat_hi) r_result <= P_MAX;
            else if (w_sat_lo) r_result <= P_MIN;
            else               r_result <= '0;
          end
        end
        S_BUILD: begin
          if (r_run != '0)  r_run  <= r_run - 1'b1;
          else if (r_term)  r_term <= 1'b0;
          else              r_field <= r_field << 1;
          if (w_last) begin
            r_guard  <= w_bit;
            r_sticky <= |w_field_next;
          end else begin
            r_body <= {r_body[N-3:0], w_bit};
          end
          r_cnt <= r_cnt + 1'b1;
        end
        S_ROUND: r_result <= {1'b0, w_rounded};
        S_SIGN: begin
          if (r_sign) r_result <= (~r_result) + {{(N-1){1'b0}}, 1'b1};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_posit_encoder_rne.sv
// Self-checking bench for posit_encoder_rne (N=32, ES=2, MW=32).
module tb_posit_encoder_rne;

  localparam int N  = 32;
  localparam int ES = 2;
  localparam int MW = 32;
  localparam int KW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sign = 1'b0;
  logic [KW-1:0] in_k = '0;
  logic [ES-1:0] in_exp = '0;
  logic [MW-1:0] in_frac = '0;
  logic          in_zero = 1'b0;
  logic          in_nar = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  out_posit;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  posit_encoder_rne #(.N(N), .ES(ES), .MW(MW), .KW(KW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_k(in_k), .in_exp(in_exp), .in_frac(in_frac),
    .in_zero(in_zero), .in_nar(in_nar),
    .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Reference: concatenate regime/exponent/fraction as one wide number,
  // left-align it, cut body/guard/sticky and round arithmetically.
  function automatic logic [31:0] model(input bit s, input int k, input logic [1:0] e,
                                        input logic [31:0] f, input bit z, input bit na);
    logic [127:0] st;
    int           rlen;
    logic [30:0]  body;
    bit           g, sk, up;
    logic [31:0]  r;
    if (na) return 32'h8000_0000;
    if (z) return 32'h0;
    if (k >= N - 2) r = 32'h7FFF_FFFF;
    else if (k <= -(N - 1)) r = 32'h0000_0001;
    else begin
      if (k >= 0) begin st = ((128'd1 << (k + 1)) - 128'd1) << 1; rlen = k + 2; end
      else begin st = 128'd1; rlen = 1 - k; end
      st = (st << ES) | 128'(e);
      st = (st << MW) | 128'(f);
      st = st << (128 - (rlen + ES + MW));
      body = st[127:97];
      g    = st[96];
      sk   = |st[95:0];
      up   = g & (body[0] | sk);
      if (!(body == '1 && up)) body = body + 31'(up);
      if (body == '0) body = 31'd1;
      r = {1'b0, body};
    end
    if (s) r = -r;
    return r;
  endfunction

  function automatic int model_lat(input int k, input bit z, input bit na);
    if (na || z) return 1;
    if (k >= N - 2 || k <= -(N - 1)) return 2;
    return N + 3;
  endfunction

  // Drive one request; lat = cycles from accept edge to first out_valid (-1 on timeout)
  task automatic run_op(input bit s, input int k, input logic [1:0] e, input logic [31:0] f,
                        input bit z, input bit na, input bit hold,
                        output logic [31:0] p, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    in_sign = s; in_k = k[KW-1:0]; in_exp = e; in_frac = f;
    in_zero = z; in_nar = na; in_valid = 1'b1;
    out_ready = !hold;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin lat = c; break; end
    end
    p = out_posit;
    if (!hold && lat > 0) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_posit !== 32'h0) begin n_errors++; $display("FAIL reset_out_posit: got %h expected 00000000", out_posit); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL idle_after_reset: busy %b in_ready %b expected 0/1", busy, in_ready); end
  endtask

  typedef struct {
    bit          s;
    int          k;
    logic [1:0]  e;
    logic [31:0] f;
    bit          z;
    bit          na;
    logic [31:0] exp_p;
    int          exp_lat;
  } vec_t;

  task automatic test_directed();
    vec_t        tbl[15];
    logic [31:0] p;
    int          lat;
    tbl[0]  = '{1'b0,   0, 2'd0, 32'h0000_0000, 1'b0, 1'b0, 32'h4000_0000, 35};
    tbl[1]  = '{1'b1,   0, 2'd0, 32'h0000_0000, 1'b0, 1'b0, 32'hC000_0000, 35};
    tbl[2]  = '{1'b0,  -1, 2'd0, 32'h0000_0000, 1'b0, 1'b0, 32'h2000_0000, 35};
    tbl[3]  = '{1'b0,   0, 2'd3, 32'h8000_0000, 1'b0, 1'b0, 32'h5C00_0000, 35};
    tbl[4]  = '{1'b0,   0, 2'd0, 32'h0000_0010, 1'b0, 1'b0, 32'h4000_0000, 35};
    tbl[5]  = '{1'b0,   0, 2'd0, 32'h0000_0030, 1'b0, 1'b0, 32'h4000_0002, 35};
    tbl[6]  = '{1'b0,   0, 2'd0, 32'h0000_0011, 1'b0, 1'b0, 32'h4000_0001, 35};
    tbl[7]  = '{1'b0,  30, 2'd1, 32'h1234_5678, 1'b0, 1'b0, 32'h7FFF_FFFF, 2};
    tbl[8]  = '{1'b0, -31, 2'd2, 32'h8765_4321, 1'b0, 1'b0, 32'h0000_0001, 2};
    tbl[9]  = '{1'b0,  29, 2'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h7FFF_FFFF, 35};
    tbl[10] = '{1'b1,   5, 2'd2, 32'h0000_1234, 1'b0, 1'b1, 32'h8000_0000, 1};
    tbl[11] = '{1'b1,   3, 2'd1, 32'hAAAA_5555, 1'b1, 1'b0, 32'h0000_0000, 1};
    tbl[12] = '{1'b0,   0, 2'd0, 32'h0000_0000, 1'b1, 1'b1, 32'h8000_0000, 1};
    tbl[13] = '{1'b1,  30, 2'd0, 32'h0000_0000, 1'b0, 1'b0, 32'h8000_0001, 2};
    tbl[14] = '{1'b1, -31, 2'd0, 32'h0000_0000, 1'b0, 1'b0, 32'hFFFF_FFFF, 2};
    foreach (tbl[i]) begin
      run_op(tbl[i].s, tbl[i].k, tbl[i].e, tbl[i].f, tbl[i].z, tbl[i].na, 1'b0, p, lat);
      n_checks++;
      if (p !== tbl[i].exp_p) begin
        n_errors++; $display("FAIL directed_%0d value: got %h expected %h", i, p, tbl[i].exp_p);
      end
      n_checks++;
      if (lat != tbl[i].exp_lat) begin
        n_errors++; $display("FAIL directed_%0d latency: got %0d expected %0d", i, lat, tbl[i].exp_lat);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] p, f, exp_p;
    logic [1:0]  e;
    int          lat, k;
    bit          s, z, na;
    for (int i = 0; i < 200; i++) begin
      s  = 1'($urandom_range(0, 1));
      k  = int'($urandom_range(0, 62)) - 31;
      e  = 2'($urandom_range(0, 3));
      f  = $urandom;
      if ($urandom_range(0, 3) == 0) f[7:0] = 8'h00;
      z  = ($urandom_range(0, 15) == 0);
      na = ($urandom_range(0, 15) == 0);
      exp_p = model(s, k, e, f, z, na);
      run_op(s, k, e, f, z, na, 1'b0, p, lat);
      n_checks++;
      if (p !== exp_p) begin
        n_errors++; $display("FAIL random_%0d value (s=%0d k=%0d e=%0d f=%h z=%0d nar=%0d): got %h expected %h",
                             i, s, k, e, f, z, na, p, exp_p);
      end
      n_checks++;
      if (lat != model_lat(k, z, na)) begin
        n_errors++; $display("FAIL random_%0d latency: got %0d expected %0d", i, lat, model_lat(k, z, na));
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] p, exp_p;
    int          lat;
    exp_p = model(1'b1, 2, 2'd1, 32'h9ABC_DEF0, 1'b0, 1'b0);
    run_op(1'b1, 2, 2'd1, 32'h9ABC_DEF0, 1'b0, 1'b0, 1'b1, p, lat);
    n_checks++;
    if (lat != 35) begin n_errors++; $display("FAIL hold_latency: got %0d expected 35", lat); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_posit !== exp_p || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_errors++; $display("FAIL hold_cycle_%0d: posit %h valid %b in_ready %b expected %h/1/0",
                             c, out_posit, out_valid, in_ready, exp_p);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++; $display("FAIL hold_release: in_ready %b out_valid %b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] p;
    int          lat;
    @(negedge clk);
    in_sign = 1'b0; in_k = 6'd3; in_exp = 2'd2; in_frac = 32'h1357_9BDF;
    in_zero = 1'b0; in_nar = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_posit !== 32'h0) begin
      n_errors++; $display("FAIL mid_reset: valid %b in_ready %b busy %b posit %h expected 0/1/0/00000000",
                           out_valid, in_ready, busy, out_posit);
    end
    @(negedge clk);
    rst = 1'b1;
    run_op(1'b0, 3, 2'd2, 32'h1357_9BDF, 1'b0, 1'b0, 1'b0, p, lat);
    n_checks++;
    if (p !== model(1'b0, 3, 2'd2, 32'h1357_9BDF, 1'b0, 1'b0) || lat != 35) begin
      n_errors++; $display("FAIL mid_recover: got %h lat %0d expected %h lat 35",
                           p, lat, model(1'b0, 3, 2'd2, 32'h1357_9BDF, 1'b0, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa, pb;
    int          first_ov, first_rdy, lat, w;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    in_sign = 1'b0; in_k = 6'd0; in_exp = 2'd0; in_frac = 32'h0;
    in_zero = 1'b0; in_nar = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_sign = 1'b1; in_k = 6'h3F; in_exp = 2'd0; in_frac = 32'h0;
    first_ov = -1; first_rdy = -1; pa = 'x;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1 && first_ov < 0) begin first_ov = c; pa = out_posit; end
      if (in_ready === 1'b1) begin first_rdy = c; break; end
    end
    n_checks++;
    if (first_ov != 35 || pa !== 32'h4000_0000) begin
      n_errors++; $display("FAIL b2b_first: got %h at cycle %0d expected 40000000 at 35", pa, first_ov);
    end
    n_checks++;
    if (first_rdy != 36) begin
      n_errors++; $display("FAIL b2b_ready: in_ready at cycle %0d expected 36", first_rdy);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1; pb = 'x;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin lat = c; pb = out_posit; break; end
    end
    n_checks++;
    if (lat != 35 || pb !== 32'hE000_0000) begin
      n_errors++; $display("FAIL b2b_second: got %h lat %0d expected e0000000 lat 35", pb, lat);
    end
    @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
